// File: rtl/rv64_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : rv64_exec_unit
// Brief    : RV64I execute stage: 32x64 register file, ALU, jump targets and a
//            load/store port. Define RV64M_EN to enable RV64M mul/div ops.
// Revision : 1.0 - initial release
// ============================================================================
module rv64_exec_unit #(
    parameter int XLEN            = 64,
    parameter int RESET_PC_UNUSED = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      op,
    input  logic            use_imm,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic [2:0]      mem_size,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [2:0]      mem_be_size,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            done,
    output logic [XLEN-1:0] wb_data,
    output logic            redirect,
    output logic [XLEN-1:0] target,
    output logic            illegal,
    input  logic [4:0]      dbg_idx,
    output logic [XLEN-1:0] dbg_data
);

    localparam logic [5:0] c_op_nop    = 6'd0;
    localparam logic [5:0] c_op_add    = 6'd1;
    localparam logic [5:0] c_op_sub    = 6'd2;
    localparam logic [5:0] c_op_sll    = 6'd3;
    localparam logic [5:0] c_op_slt    = 6'd4;
    localparam logic [5:0] c_op_sltu   = 6'd5;
    localparam logic [5:0] c_op_xor    = 6'd6;
    localparam logic [5:0] c_op_srl    = 6'd7;
    localparam logic [5:0] c_op_sra    = 6'd8;
    localparam logic [5:0] c_op_or     = 6'd9;
    localparam logic [5:0] c_op_and    = 6'd10;
    localparam logic [5:0] c_op_addw   = 6'd11;
    localparam logic [5:0] c_op_subw   = 6'd12;
    localparam logic [5:0] c_op_sllw   = 6'd13;
    localparam logic [5:0] c_op_srlw   = 6'd14;
    localparam logic [5:0] c_op_sraw   = 6'd15;
    localparam logic [5:0] c_op_lui    = 6'd16;
    localparam logic [5:0] c_op_auipc  = 6'd17;
    localparam logic [5:0] c_op_jal    = 6'd18;
    localparam logic [5:0] c_op_jalr   = 6'd19;
    localparam logic [5:0] c_op_load   = 6'd20;
    localparam logic [5:0] c_op_store  = 6'd21;
`ifdef RV64M_EN
    localparam logic [5:0] c_op_mul    = 6'd22;
    localparam logic [5:0] c_op_mulh   = 6'd23;
    localparam logic [5:0] c_op_mulhsu = 6'd24;
    localparam logic [5:0] c_op_mulhu  = 6'd25;
    localparam logic [5:0] c_op_div    = 6'd26;
    localparam logic [5:0] c_op_divu   = 6'd27;
    localparam logic [5:0] c_op_rem    = 6'd28;
    localparam logic [5:0] c_op_remu   = 6'd29;
    localparam logic [5:0] c_op_mulw   = 6'd30;
    localparam logic [5:0] c_op_divw   = 6'd31;
    localparam logic [5:0] c_op_divuw  = 6'd32;
    localparam logic [5:0] c_op_remw   = 6'd33;
    localparam logic [5:0] c_op_remuw  = 6'd34;
    localparam logic [XLEN-1:0] c_min = {1'b1, {(XLEN-1){1'b0}}};
`endif

    generate
        if (XLEN != 64 || RESET_PC_UNUSED != 0) begin : g_cfg_check
            $error("rv64_exec_unit supports only XLEN=64 and RESET_PC_UNUSED=0");
        end
    endgenerate

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_LOAD = 1'b1} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_regs [32];
    logic [4:0]      r_ld_rd;
    logic            r_done, r_redirect, r_illegal, r_req, r_we;
    logic [XLEN-1:0] r_wb, r_target, r_addr, r_wdata;
    logic [2:0]      r_be;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // Size 7 is undefined and falls through to the full doubleword.
    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] sz, input logic [XLEN-1:0] d);
        case (sz)
            3'd0:    return {{(XLEN-8){d[7]}}, d[7:0]};
            3'd1:    return {{(XLEN-16){d[15]}}, d[15:0]};
            3'd2:    return sext32(d[31:0]);
            3'd4:    return {{(XLEN-8){1'b0}}, d[7:0]};
            3'd5:    return {{(XLEN-16){1'b0}}, d[15:0]};
            3'd6:    return {{(XLEN-32){1'b0}}, d[31:0]};
            default: return d;
        endcase
    endfunction

    logic [XLEN-1:0] w_a, w_rs2, w_b, w_addr, w_upimm, w_pc4, w_sra;
    logic [31:0]     w_addw, w_subw, w_sllw, w_srlw, w_sraw;
    logic [XLEN-1:0] w_res, w_target;
    logic            w_wen, w_illegal, w_redirect, w_is_load, w_is_store;

    assign w_a     = (rs1 == 5'd0) ? '0 : r_regs[rs1];
    assign w_rs2   = (rs2 == 5'd0) ? '0 : r_regs[rs2];
    assign w_b     = use_imm ? imm : w_rs2;
    assign w_addr  = w_a + imm;
    assign w_upimm = sext32({imm[19:0], 12'h000});
    assign w_pc4   = pc + XLEN'(4);
    assign w_sra   = $unsigned($signed(w_a) >>> w_b[5:0]);
    assign w_addw  = w_a[31:0] + w_b[31:0];
    assign w_subw  = w_a[31:0] - w_b[31:0];
    assign w_sllw  = w_a[31:0] << w_b[4:0];
    assign w_srlw  = w_a[31:0] >> w_b[4:0];
    assign w_sraw  = $unsigned($signed(w_a[31:0]) >>> w_b[4:0]);

`ifdef RV64M_EN
    logic              w_msa, w_msb, w_dz, w_ovf, w_dzw, w_ovfw;
    logic [2*XLEN-1:0] w_prod;
    logic [31:0]       w_mulw, w_bdsw, w_bduw, w_quo_sw, w_rem_sw, w_quo_uw, w_rem_uw;
    logic [XLEN-1:0]   w_bds, w_bdu, w_quo_s, w_rem_s, w_quo_u, w_rem_u;

    // One 128-bit multiplier; sign-extending per op yields all three high forms.
    assign w_msa  = (op == c_op_mulh) || (op == c_op_mulhsu);
    assign w_msb  = (op == c_op_mulh);
    assign w_prod = {{XLEN{w_msa & w_a[XLEN-1]}}, w_a} * {{XLEN{w_msb & w_b[XLEN-1]}}, w_b};
    assign w_mulw = w_a[31:0] * w_b[31:0];

    assign w_dz   = (w_b == '0);
    assign w_ovf  = (w_a == c_min) && (w_b == '1);
    assign w_dzw  = (w_b[31:0] == 32'd0);
    assign w_ovfw = (w_a[31:0] == 32'h8000_0000) && (w_b[31:0] == 32'hFFFF_FFFF);
    // Dividers see a harmless divisor in the special cases; the muxes override them.
    assign w_bds  = (w_dz || w_ovf) ? XLEN'(1) : w_b;
    assign w_bdu  = w_dz ? XLEN'(1) : w_b;
    assign w_bdsw = (w_dzw || w_ovfw) ? 32'd1 : w_b[31:0];
    assign w_bduw = w_dzw ? 32'd1 : w_b[31:0];

    assign w_quo_s  = w_dz ? '1 : w_ovf ? c_min : $unsigned($signed(w_a) / $signed(w_bds));
    assign w_rem_s  = w_dz ? w_a : w_ovf ? '0 : $unsigned($signed(w_a) % $signed(w_bds));
    assign w_quo_u  = w_dz ? '1 : w_a / w_bdu;
    assign w_rem_u  = w_dz ? w_a : w_a % w_bdu;
    assign w_quo_sw = w_dzw ? '1 : w_ovfw ? 32'h8000_0000
                    : $unsigned($signed(w_a[31:0]) / $signed(w_bdsw));
    assign w_rem_sw = w_dzw ? w_a[31:0] : w_ovfw ? 32'd0
                    : $unsigned($signed(w_a[31:0]) % $signed(w_bdsw));
    assign w_quo_uw = w_dzw ? '1 : w_a[31:0] / w_bduw;
    assign w_rem_uw = w_dzw ? w_a[31:0] : w_a[31:0] % w_bduw;
`endif

    always_comb begin
        w_res      = '0;
        w_target   = '0;
        w_wen      = 1'b1;
        w_illegal  = 1'b0;
        w_redirect = 1'b0;
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        case (op)
            c_op_nop:    w_wen = 1'b0;
            c_op_add:    w_res = w_a + w_b;
            c_op_sub:    w_res = w_a - w_b;
            c_op_sll:    w_res = w_a << w_b[5:0];
            c_op_slt:    w_res = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
            c_op_sltu:   w_res = {{(XLEN-1){1'b0}}, w_a < w_b};
            c_op_xor:    w_res = w_a ^ w_b;
            c_op_srl:    w_res = w_a >> w_b[5:0];
            c_op_sra:    w_res = w_sra;
            c_op_or:     w_res = w_a | w_b;
            c_op_and:    w_res = w_a & w_b;
            c_op_addw:   w_res = sext32(w_addw);
            c_op_subw:   w_res = sext32(w_subw);
            c_op_sllw:   w_res = sext32(w_sllw);
            c_op_srlw:   w_res = sext32(w_srlw);
            c_op_sraw:   w_res = sext32(w_sraw);
            c_op_lui:    w_res = w_upimm;
            c_op_auipc:  w_res = pc + w_upimm;
            c_op_jal: begin
                w_res      = w_pc4;
                w_redirect = 1'b1;
                w_target   = imm;
            end
            c_op_jalr: begin
                w_res      = w_pc4;
                w_redirect = 1'b1;
                w_target   = w_addr & ~XLEN'(1);
            end
            c_op_load: begin
                w_wen     = 1'b0;
                w_is_load = 1'b1;
            end
            c_op_store: begin
                w_wen      = 1'b0;
                w_is_store = 1'b1;
            end
`ifdef RV64M_EN
            c_op_mul:    w_res = w_prod[XLEN-1:0];
            c_op_mulh,
            c_op_mulhsu,
            c_op_mulhu:  w_res = w_prod[2*XLEN-1:XLEN];
            c_op_div:    w_res = w_quo_s;
            c_op_divu:   w_res = w_quo_u;
            c_op_rem:    w_res = w_rem_s;
            c_op_remu:   w_res = w_rem_u;
            c_op_mulw:   w_res = sext32(w_mulw);
            c_op_divw:   w_res = sext32(w_quo_sw);
            c_op_divuw:  w_res = sext32(w_quo_uw);
            c_op_remw:   w_res = sext32(w_rem_sw);
            c_op_remuw:  w_res = sext32(w_rem_uw);
`endif
            default: begin
                w_wen     = 1'b0;
                w_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
            r_state    <= S_IDLE;
            r_ld_rd    <= '0;
            r_done     <= 1'b0;
            r_wb       <= '0;
            r_redirect <= 1'b0;
            r_target   <= '0;
            r_illegal  <= 1'b0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_wb       <= '0;
            r_redirect <= 1'b0;
            r_target   <= '0;
            r_illegal  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_req <= 1'b0;
                    r_we  <= 1'b0;
                    if (in_valid) begin
                        r_done     <= !w_is_load;
                        r_illegal  <= w_illegal;
                        r_redirect <= w_redirect;
                        r_target   <= w_target;
                        if (w_wen && rd != 5'd0) begin
                            r_regs[rd] <= w_res;
                            r_wb       <= w_res;
                        end
                        if (w_is_store || w_is_load) begin
                            r_req  <= 1'b1;
                            r_we   <= w_is_store;
                            r_addr <= w_addr;
                            r_be   <= mem_size;
                        end
                        if (w_is_store) r_wdata <= w_rs2;
                        if (w_is_load) begin
                            r_ld_rd <= rd;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (mem_rvalid) begin
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                        if (r_ld_rd != 5'd0) begin
                            r_regs[r_ld_rd] <= load_ext(r_be, mem_rdata);
                            r_wb            <= load_ext(r_be, mem_rdata);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign done        = r_done;
    assign wb_data     = r_wb;
    assign redirect    = r_redirect;
    assign target      = r_target;
    assign illegal     = r_illegal;
    assign mem_req     = r_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_be_size = r_be;
    assign dbg_data    = (dbg_idx == 5'd0) ? '0 : r_regs[dbg_idx];

endmodule
`default_nettype wire

// File: tb/tb_rv64_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv64_exec_unit
// Brief    : Directed and randomized self-checking bench for rv64_exec_unit
//            against an arithmetic reference model (honours RV64M_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv64_exec_unit;

`ifdef RV64M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    localparam logic [5:0] OP_ADD = 6'd1, OP_SRL = 6'd7, OP_SRA = 6'd8, OP_SRAW = 6'd15;
    localparam logic [5:0] OP_LUI = 6'd16, OP_AUIPC = 6'd17, OP_JALR = 6'd19;
    localparam logic [5:0] OP_LOAD = 6'd20, OP_STORE = 6'd21, OP_MUL = 6'd22;
    localparam logic [5:0] OP_MULHU = 6'd25, OP_DIV = 6'd26, OP_REM = 6'd28;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, use_imm;
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2, dbg_idx;
    logic [63:0] imm, pc, mem_addr, mem_wdata, mem_rdata, wb_data, target, dbg_data;
    logic [2:0]  mem_size, mem_be_size;
    logic        mem_req, mem_we, mem_rvalid, done, redirect, illegal;

    int checks = 0;
    int errors = 0;
    logic [63:0] mregs [32];

    rv64_exec_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .use_imm(use_imm), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .pc(pc), .mem_size(mem_size), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be_size(mem_be_size),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .done(done),
        .wb_data(wb_data), .redirect(redirect), .target(target),
        .illegal(illegal), .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic dbg_chk(input string tag, input logic [4:0] idx, input logic [63:0] exp);
        dbg_idx = idx;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    task automatic issue(input logic [5:0] o, input logic ui, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic [63:0] im, input logic [63:0] p, input logic [2:0] ms);
        op = o; use_imm = ui; rd = d; rs1 = s1; rs2 = s2; imm = im; pc = p; mem_size = ms;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Schoolbook 32-bit-limb product, independent of any 128-bit multiply.
    function automatic logic [63:0] mulhu(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ll, lh, hl, hh, mid;
        ll  = {32'b0, a[31:0]}  * {32'b0, b[31:0]};
        lh  = {32'b0, a[31:0]}  * {32'b0, b[63:32]};
        hl  = {32'b0, a[63:32]} * {32'b0, b[31:0]};
        hh  = {32'b0, a[63:32]} * {32'b0, b[63:32]};
        mid = {32'b0, ll[63:32]} + {32'b0, lh[31:0]} + {32'b0, hl[31:0]};
        return hh + {32'b0, lh[63:32]} + {32'b0, hl[63:32]} + {32'b0, mid[63:32]};
    endfunction

    function automatic logic [63:0] ld_ext(input logic [63:0] r, input logic [2:0] ms);
        case (ms)
            3'd0:    return {{56{r[7]}}, r[7:0]};
            3'd1:    return {{48{r[15]}}, r[15:0]};
            3'd2:    return sx32(r[31:0]);
            3'd4:    return {56'b0, r[7:0]};
            3'd5:    return {48'b0, r[15:0]};
            3'd6:    return {32'b0, r[31:0]};
            default: return r;
        endcase
    endfunction

    task automatic model(input logic [5:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] im, input logic [63:0] p,
                         output logic [63:0] res, output bit wr, output bit ill,
                         output bit redir, output logic [63:0] tgt);
        logic [63:0] hu;
        logic signed [31:0] ai, bi;
        logic [31:0] au, bu, t32;
        res = '0; wr = 1'b1; ill = 1'b0; redir = 1'b0; tgt = '0;
        ai = a[31:0]; bi = b[31:0]; au = a[31:0]; bu = b[31:0];
        hu = mulhu(a, b);
        t32 = {im[19:0], 12'h000};
        if (o > 6'd34 || (!M_EN && o >= 6'd22)) begin
            ill = 1'b1; wr = 1'b0;
        end else begin
            case (o)
                6'd1:  res = a + b;
                6'd2:  res = a - b;
                6'd3:  res = a << b[5:0];
                6'd4:  res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                6'd5:  res = (a < b) ? 64'd1 : 64'd0;
                6'd6:  res = a ^ b;
                6'd7:  res = a >> b[5:0];
                6'd8:  res = $signed(a) >>> b[5:0];
                6'd9:  res = a | b;
                6'd10: res = a & b;
                6'd11: res = sx32(au + bu);
                6'd12: res = sx32(au - bu);
                6'd13: res = sx32(au << b[4:0]);
                6'd14: res = sx32(au >> b[4:0]);
                6'd15: res = sx32(ai >>> b[4:0]);
                6'd16: res = sx32(t32);
                6'd17: res = p + sx32(t32);
                6'd18: begin res = p + 64'd4; redir = 1'b1; tgt = im; end
                6'd19: begin res = p + 64'd4; redir = 1'b1; tgt = (a + im) & ~64'd1; end
                6'd22: res = a * b;
                6'd23: res = hu - (a[63] ? b : 64'd0) - (b[63] ? a : 64'd0);
                6'd24: res = hu - (a[63] ? b : 64'd0);
                6'd25: res = hu;
                6'd26: res = (b == 0) ? '1 : (a == 64'h8000_0000_0000_0000 && b == '1) ? a
                           : 64'($signed(a) / $signed(b));
                6'd27: res = (b == 0) ? '1 : a / b;
                6'd28: res = (b == 0) ? a : (a == 64'h8000_0000_0000_0000 && b == '1) ? 64'd0
                           : 64'($signed(a) % $signed(b));
                6'd29: res = (b == 0) ? a : a % b;
                6'd30: res = sx32(au * bu);
                6'd31: res = (bu == 0) ? '1 : (au == 32'h8000_0000 && bu == '1) ? sx32(au)
                           : sx32(32'(ai / bi));
                6'd32: res = (bu == 0) ? '1 : sx32(au / bu);
                6'd33: res = (bu == 0) ? sx32(au) : (au == 32'h8000_0000 && bu == '1) ? 64'd0
                           : sx32(32'(ai % bi));
                6'd34: res = (bu == 0) ? sx32(au) : sx32(au % bu);
                default: wr = 1'b0;
            endcase
        end
    endtask

    task automatic exec_check(input logic [5:0] o, input logic ui, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2,
                              input logic [63:0] im, input logic [63:0] p,
                              input logic [2:0] ms, input int lat);
        logic [63:0] a, b, res, tgt, rdat;
        bit wr, ill, redir;
        a = mregs[s1];
        b = ui ? im : mregs[s2];
        model(o, a, b, im, p, res, wr, ill, redir, tgt);
        issue(o, ui, d, s1, s2, im, p, ms);
        if (o == OP_LOAD) begin
            chk("r_ld_req", mem_req, 64'd1);
            chk("r_ld_addr", mem_addr, a + im);
            rdat = {$urandom, $urandom};
            for (int k = 0; k <= lat; k++) begin
                chk("r_ld_ready", in_ready, 64'd0);
                if (k == lat) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdat;
                end
                @(posedge clk);
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
            res = ld_ext(rdat, ms);
            wr  = 1'b1;
        end
        chk("r_done", done, 64'd1);
        chk("r_wb", wb_data, (wr && d != 0) ? res : 64'd0);
        chk("r_illegal", illegal, {63'b0, ill});
        chk("r_redirect", redirect, {63'b0, redir});
        if (redir) chk("r_target", target, tgt);
        if (o == OP_STORE) begin
            chk("r_st_req", {mem_req, mem_we}, 64'd3);
            chk("r_st_addr", mem_addr, a + im);
            chk("r_st_data", mem_wdata, mregs[s2]);
            chk("r_st_size", mem_be_size, {61'b0, ms});
        end
        chk("r_ready", in_ready, 64'd1);
        if (wr && d != 0) mregs[d] = res;
    endtask

    initial begin
        logic [63:0] lexp [2];
        logic [5:0] ro;
        reset = 1'b1; in_valid = 1'b0; op = '0; use_imm = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
        imm = '0; pc = '0; mem_size = '0; mem_rvalid = 1'b0; mem_rdata = '0; dbg_idx = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", in_ready, 64'd1);
        chk("rst_done", {done, mem_req, redirect, illegal}, 64'd0);
        chk("rst_wb", wb_data, 64'd0);
        dbg_chk("rst_x5", 5'd5, 64'd0);

        issue(OP_ADD, 1'b1, 5'd5, 5'd0, 5'd0, '1, 64'd0, 3'd0);
        chk("add_done", done, 64'd1);
        chk("add_wb", wb_data, '1);
        dbg_chk("add_x5", 5'd5, '1);
        issue(OP_ADD, 1'b1, 5'd0, 5'd5, 5'd0, 64'd3, 64'd0, 3'd0);
        dbg_chk("x0_zero", 5'd0, 64'd0);
        chk("x0_wb", wb_data, 64'd0);

        issue(OP_ADD, 1'b1, 5'd1, 5'd0, 5'd0, 64'h8000_0000_0000_0000, 64'd0, 3'd0);
        issue(OP_SRA, 1'b1, 5'd6, 5'd1, 5'd0, 64'd63, 64'd0, 3'd0);
        chk("sra63", wb_data, '1);
        issue(OP_SRL, 1'b1, 5'd6, 5'd1, 5'd0, 64'd63, 64'd0, 3'd0);
        chk("srl63", wb_data, 64'd1);
        issue(OP_ADD, 1'b1, 5'd1, 5'd0, 5'd0, 64'h8000_0000, 64'd0, 3'd0);
        issue(OP_SRAW, 1'b1, 5'd6, 5'd1, 5'd0, 64'd4, 64'd0, 3'd0);
        chk("sraw4", wb_data, 64'hFFFF_FFFF_F800_0000);

        issue(OP_LUI, 1'b1, 5'd7, 5'd0, 5'd0, 64'h8_0000, 64'd0, 3'd0);
        chk("lui", wb_data, 64'hFFFF_FFFF_8000_0000);
        issue(OP_AUIPC, 1'b1, 5'd7, 5'd0, 5'd0, 64'd1, 64'h1000, 3'd0);
        chk("auipc", wb_data, 64'h2000);
        issue(OP_ADD, 1'b1, 5'd2, 5'd0, 5'd0, 64'h203, 64'd0, 3'd0);
        issue(OP_JALR, 1'b1, 5'd2, 5'd2, 5'd0, 64'd0, 64'h100, 3'd0);
        chk("jalr_tgt", target, 64'h202);
        chk("jalr_rd", wb_data, 64'h104);
        chk("jalr_redir", redirect, 64'd1);
        dbg_chk("jalr_x2", 5'd2, 64'h104);

        issue(OP_ADD, 1'b1, 5'd3, 5'd0, 5'd0, 64'h1000, 64'd0, 3'd0);
        lexp[0] = 64'hFFFF_FFFF_FFFF_FF80;
        lexp[1] = 64'h80;
        for (int t = 0; t < 2; t++) begin
            issue(OP_LOAD, 1'b1, 5'd7, 5'd3, 5'd0, 64'd4, 64'd0, (t == 0) ? 3'd0 : 3'd4);
            chk("ld_req", {mem_req, mem_we}, 64'd2);
            chk("ld_addr", mem_addr, 64'h1004);
            chk("ld_nodone", done, 64'd0);
            for (int k = 0; k < 3; k++) begin
                chk("ld_busy", in_ready, 64'd0);
                if (k == 0) begin
                    in_valid = 1'b1; op = OP_ADD; use_imm = 1'b1; rd = 5'd12; rs1 = 5'd0; imm = 64'h99;
                end
                if (k == 2) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 64'h80;
                end
                @(posedge clk);
                @(negedge clk);
                in_valid = 1'b0;
            end
            mem_rvalid = 1'b0;
            chk("ld_done", done, 64'd1);
            chk("ld_wb", wb_data, lexp[t]);
            chk("ld_end", {in_ready, mem_req}, 64'd2);
            dbg_chk("ld_ignored_issue", 5'd12, 64'd0);
        end

        issue(OP_ADD, 1'b1, 5'd4, 5'd0, 5'd0, 64'h1122_3344_5566_7788, 64'd0, 3'd0);
        issue(OP_STORE, 1'b1, 5'd0, 5'd3, 5'd4, 64'd8, 64'd0, 3'd3);
        chk("st_req", {mem_req, mem_we, done}, 64'd7);
        chk("st_addr", mem_addr, 64'h1008);
        chk("st_data", mem_wdata, 64'h1122_3344_5566_7788);
        chk("st_size", mem_be_size, 64'd3);
        @(posedge clk);
        @(negedge clk);
        chk("st_single", {mem_req, done}, 64'd0);

        issue(OP_ADD, 1'b1, 5'd8, 5'd0, 5'd0, 64'd7, 64'd0, 3'd0);
        issue(OP_ADD, 1'b1, 5'd9, 5'd0, 5'd0, 64'h55, 64'd0, 3'd0);
`ifdef RV64M_EN
        issue(OP_DIV, 1'b0, 5'd9, 5'd8, 5'd0, 64'd0, 64'd0, 3'd0);
        chk("div0", wb_data, '1);
        issue(OP_REM, 1'b0, 5'd9, 5'd8, 5'd0, 64'd0, 64'd0, 3'd0);
        chk("rem0", wb_data, 64'd7);
        issue(OP_ADD, 1'b1, 5'd11, 5'd0, 5'd0, 64'h8000_0000_0000_0000, 64'd0, 3'd0);
        issue(OP_DIV, 1'b0, 5'd9, 5'd11, 5'd5, 64'd0, 64'd0, 3'd0);
        chk("div_ovf", wb_data, 64'h8000_0000_0000_0000);
        issue(OP_ADD, 1'b1, 5'd10, 5'd0, 5'd0, 64'd2, 64'd0, 3'd0);
        issue(OP_MULHU, 1'b0, 5'd9, 5'd5, 5'd10, 64'd0, 64'd0, 3'd0);
        chk("mulhu", wb_data, 64'd1);
        issue(OP_ADD, 1'b1, 5'd9, 5'd0, 5'd0, 64'h55, 64'd0, 3'd0);
`else
        issue(OP_MUL, 1'b0, 5'd9, 5'd8, 5'd8, 64'd0, 64'd0, 3'd0);
        chk("mul_illegal", {done, illegal}, 64'd3);
        chk("mul_wb", wb_data, 64'd0);
        dbg_chk("mul_nowrite", 5'd9, 64'h55);
`endif
        issue(6'd40, 1'b1, 5'd9, 5'd0, 5'd0, 64'd1, 64'd0, 3'd0);
        chk("op40_illegal", {done, illegal}, 64'd3);
        dbg_chk("op40_nowrite", 5'd9, 64'h55);

        issue(OP_LOAD, 1'b1, 5'd7, 5'd3, 5'd0, 64'd0, 64'd0, 3'd3);
        reset = 1'b1;
        #1;
        chk("rst_ld_req", mem_req, 64'd0);
        chk("rst_ld_ready", in_ready, 64'd1);
        for (int i = 0; i < 32; i++) dbg_chk("rst_regs", i[4:0], 64'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_rvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("stray_rvalid", {done, in_ready}, 64'd1);

        for (int i = 0; i < 32; i++) mregs[i] = '0;
        for (int i = 1; i < 32; i++)
            exec_check(OP_ADD, 1'b1, i[4:0], 5'd0, 5'd0, {$urandom, $urandom}, 64'd0, 3'd0, 0);
        for (int n = 0; n < 300; n++) begin
            ro = 6'($urandom_range(0, 40));
            exec_check(ro, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                       ($urandom_range(0, 1) == 0) ? 64'($signed(12'($urandom))) : {$urandom, $urandom},
                       {$urandom, $urandom}, 3'($urandom), int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 32; i++) dbg_chk("final_regs", i[4:0], mregs[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv64_exec_unit.md
Name: rv64_exec_unit

Overview:
- RV64I execution core: 32x64 integer register file, ALU, jump-target generation and a simple load/store memory port, with RV64M multiply/divide as a compile option.
- Sits behind the instruction decoder. The decoder supplies a pre-decoded operation code, register indices, a sign-extended immediate and the PC.
- Results are written back to the register file. Jumps are reported as redirects.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- RESET_PC_UNUSED, 0, reserved; must stay 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation present; accepted when in_valid && in_ready.
- in_ready  out  1  high when idle; low while a load is outstanding.
- op  in  6  operation code (see Behaviour).
- use_imm  in  1  for ALU/W ops, operand B = imm instead of rs2 data.
- rd, rs1, rs2  in  5 each  register indices.
- imm  in  64  immediate, already sign-extended by the decoder.
- pc  in  64  PC of the operation.
- mem_size  in  3  funct3 for LOAD/STORE (0 b, 1 h, 2 w, 3 d, 4 bu, 5 hu, 6 wu).
- mem_req  out  1  memory request.
- mem_we  out  1  store when high.
- mem_addr  out  64  byte address.
- mem_wdata  out  64  store data.
- mem_be_size  out  3  registered copy of mem_size.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  64  load data, right-aligned.
- done  out  1  one-cycle completion pulse.
- wb_data  out  64  value written to rd (0 if rd is not written).
- redirect  out  1  jump taken (JAL/JALR); valid with done.
- target  out  64  jump target.
- illegal  out  1  op code undefined or disabled; valid with done; no state change.
- dbg_idx  in  5  debug register-read index.
- dbg_data  out  64  combinational register-file read of dbg_idx (0 for x0).

Behaviour:
- Reset: all registers x0..x31 = 0. All outputs 0. in_ready = 1. Any outstanding load is abandoned.
- Operand A = R[rs1]. Operand B = use_imm ? imm : R[rs2].
- Writes to x0 are discarded; reads of x0 return 0.
- Op codes:
  - 0 NOP; 1 ADD; 2 SUB; 3 SLL; 4 SLT; 5 SLTU; 6 XOR; 7 SRL; 8 SRA; 9 OR; 10 AND.
  - 11 ADDW; 12 SUBW; 13 SLLW; 14 SRLW; 15 SRAW.
  - 16 LUI; 17 AUIPC; 18 JAL; 19 JALR; 20 LOAD; 21 STORE.
  - 22 MUL; 23 MULH; 24 MULHSU; 25 MULHU; 26 DIV; 27 DIVU; 28 REM; 29 REMU.
  - 30 MULW; 31 DIVW; 32 DIVUW; 33 REMW; 34 REMUW.
  - Codes 35..63 are illegal.
- Shifts:
  - 64-bit ops use B[5:0]; W ops use B[4:0].
  - W ops compute on the low 32 bits and sign-extend the 32-bit result.
  - SUB with use_imm is treated as ADD of -B; the decoder never issues it.
- LUI: rd = sext(imm[19:0] << 12). AUIPC: rd = pc + sext(imm[19:0] << 12).
- JAL: rd = pc + 4; target = imm (the decoder passes the absolute target); redirect = 1.
- JALR: rd = pc + 4; target = (R[rs1] + imm) & ~1; redirect = 1. rs1 is read before rd is written, so rd == rs1 is safe.
- ALU/jump timing:
  - Accepted at edge N: register write and done/wb_data/redirect/target are all registered at edge N.
  - They are visible during cycle N+1.
  - Back-to-back issue is allowed; a dependent op at N+1 sees the new value.
- STORE:
  - At edge N: mem_req = 1, mem_we = 1, mem_addr = R[rs1] + imm, mem_wdata = R[rs2], mem_be_size = mem_size; done = 1 during N+1.
  - A store is fire-and-forget: one-cycle mem_req, no wait.
- LOAD:
  - At edge N: mem_req = 1, mem_we = 0, mem_addr = R[rs1] + imm, in_ready = 0. mem_req stays high until mem_rvalid.
  - On the edge where mem_rvalid = 1: R[rd] = mem_rdata extended per mem_size (b/h/w sign-extend, bu/hu/wu zero-extend, d unchanged). At the same edge done = 1, wb_data is set, mem_req = 0 and in_ready = 1.
  - mem_rvalid while no load is outstanding is ignored.
  - in_valid while in_ready = 0 is ignored.
  - Reset mid-load drops the load.
- Illegal mem_size (7) is treated as d.
- DIV/REM rules (RISC-V):
  - Divide by zero: quotient = all ones; remainder = dividend (W forms: sext of the 32-bit dividend).
  - Signed overflow (most-negative / -1): quotient = most-negative; remainder = 0.
- MULH/MULHSU/MULHU return the upper 64 bits of the 128-bit product.
- done is never asserted for a cycle with no accepted or completed op.

Optional Feature:
- RV64M_EN defined: op codes 22..34 execute as above, single-cycle, same timing as ALU ops.
- RV64M_EN undefined: op codes 22..34 raise illegal = 1 with done. No register write; wb_data = 0.

Test Plan:
- Reset, then ADD use_imm rd=5 rs1=0 imm=-1 -> done next cycle, wb_data = 0xFFFF_FFFF_FFFF_FFFF, dbg_idx=5 reads the same; a write to rd=0 leaves dbg x0 = 0.
- R[1] = 0x8000_0000_0000_0000; SRA imm=63 -> all ones. SRL -> 1. SRAW with R[1] = 0x8000_0000, imm=4 -> 0xFFFF_FFFF_F800_0000.
- LUI imm=0x80000 -> 0xFFFF_FFFF_8000_0000. AUIPC pc=0x1000 imm=1 -> 0x2000. JALR pc=0x100 R[2]=0x203 imm=0 -> target 0x202, rd = 0x104, redirect = 1.
- LOAD lb at addr R[3]+4, mem_rvalid after 3 cycles with rdata = 0x80 -> in_ready low for 3 cycles, then wb_data = 0xFFFF_FFFF_FFFF_FF80. Same with lbu -> 0x80. STORE sd -> a single mem_req with mem_we = 1.
- With RV64M_EN: DIV 7 by 0 -> all ones; REM -> 7; DIV 0x8000_0000_0000_0000 by -1 -> 0x8000_0000_0000_0000; MULHU all ones x 2 -> 1. Without RV64M_EN: MUL -> illegal = 1, register unchanged.
- Op code 40 -> illegal = 1, no write. Reset asserted mid-load -> mem_req = 0, in_ready = 1, all registers read 0.
